line_cmd_sched: RTL
===================

Name: line_cmd_sched

Overview:
- Arbitrates line-draw commands from two requesters and sequences one shared Bresenham line engine.
- Latches the winning command and holds its endpoints stable for the whole draw, because the engine reads its endpoint inputs combinationally on every cycle.
- Forwards the engine's pixel stream to the framebuffer write port, clipping pixels to the screen window.
- Sits between the command sources (CPU path, overlay path) and the line engine / framebuffer writer.

Parameters:
- SCR_W, 640, screen width; pixel x is valid when 0 <= x < SCR_W.
- SCR_H, 480, screen height; pixel y is valid when 0 <= y < SCR_H.
- START_TO, 15, max cycles in ST_ISSUE waiting for the engine to accept before abort.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_req0_valid  in  1  requester 0 command valid
- i_req0_line  in  64  {x1,y1,x2,y2}, each signed 16-bit
- o_req0_ack  out  1  1-cycle pulse: command latched
- o_req0_done  out  1  1-cycle pulse: line finished or aborted
- i_req1_valid, i_req1_line, o_req1_ack, o_req1_done  same as requester 0, for requester 1
- o_ln_x1, o_ln_y1, o_ln_x2, o_ln_y2  out  16 each  latched endpoints to the engine (signed)
- o_ln_start  out  1  start request to the engine
- i_ln_set_pixel  in  1  engine pixel strobe
- i_ln_x, i_ln_y  in  16 each  engine pixel coordinates (signed)
- i_ln_ready  in  1  engine idle indication
- o_pix_we  out  1  framebuffer write strobe
- o_pix_x, o_pix_y  out  16 each  write coordinates
- o_pix_owner  out  1  requester index that owns the current line
- o_busy  out  1  high in every state except ST_IDLE
- o_err  out  1  sticky; set on start timeout; cleared only by reset
- o_clip_cnt  out  16  saturating count of clipped pixels

Behaviour:
- Reset (async, rst_n=0):
  - state = ST_IDLE; all outputs = 0; rr pointer = 0; o_ln_* = 0.
- States: ST_IDLE -> ST_ISSUE -> ST_DRAW -> ST_DONE -> ST_IDLE.
- ST_IDLE arbitration:
  - Only one requester valid: that requester wins.
  - Both valid: the requester equal to rr pointer wins.
  - On a win: latch the line into o_ln_*, set owner, pulse the owner's ack for the same cycle, go to ST_ISSUE.
  - A requester must hold valid and line until it sees ack.
- ST_ISSUE:
  - o_ln_start = 1; timeout counter counts cycles.
  - i_ln_set_pixel = 1: accepted; go to ST_DRAW and forward that pixel.
  - Counter reaches START_TO without acceptance: set o_err, drop start, go to ST_DONE.
- ST_DRAW:
  - o_ln_start = 0; o_ln_* held unchanged.
  - Every i_ln_set_pixel cycle is registered to the pixel port with 1-cycle latency.
  - In-window pixel (signed compares; negative coordinates are out of window): o_pix_we = 1 with x/y.
  - Out-of-window pixel: o_pix_we = 0; o_clip_cnt increments, saturating at 0xFFFF.
  - i_ln_ready = 1 with i_ln_set_pixel = 0: go to ST_DONE. The engine's ready only rises after its last pixel.
- ST_DONE:
  - Pulse the owner's done for 1 cycle; rr pointer = ~owner; go to ST_IDLE.
  - No arbitration in this cycle, so the minimum command-to-command gap is 1 idle cycle.
- Other rules:
  - New valids during ST_ISSUE, ST_DRAW or ST_DONE are ignored, and no ack is given.
  - Simultaneous ack and done cannot occur.
  - Reset mid-draw aborts immediately: no done pulse; pixel port goes low asynchronously.
  - Degenerate line (x1=x2, y1=y2) is a normal command; the engine emits it as one point.

Test Plan:
- Req0 alone, line (0,0)-(3,1): ack0 1 cycle after valid, then writes (0,0),(1,0),(2,1),(3,1) in order, each 1 cycle after its set_pixel; done0 once; o_clip_cnt = 0.
- Both valid in the same cycle, twice in a row: first grant req0 (rr=0), second grant req1; ack pulses never overlap.
- Line (-2,5)-(2,5): 5 pixels from the engine; writes only at x=0,1,2; o_clip_cnt = 2.
- Engine model never asserts set_pixel: after 15 cycles in ST_ISSUE, o_err = 1, done pulses, state returns to ST_IDLE, next command is accepted.
- rst_n low mid-draw: all outputs 0 immediately; no done pulse; rr pointer = 0 after reset release.
- Req1 changes i_req1_line during the draw: o_ln_* stay at the latched values until done.

Source files
------------

// File: rtl/line_cmd_sched_if.sv
// Bundles the two requester ports, the line-engine port and the framebuffer
// write port of line_cmd_sched. The scheduler uses the slave view, its environment uses the master view.
interface line_cmd_sched_if;
  logic        i_req0_valid;
  logic [63:0] i_req0_line;
  logic        o_req0_ack;
  logic        o_req0_done;
  logic        i_req1_valid;
  logic [63:0] i_req1_line;
  logic        o_req1_ack;
  logic        o_req1_done;
  logic [15:0] o_ln_x1;
  logic [15:0] o_ln_y1;
  logic [15:0] o_ln_x2;
  logic [15:0] o_ln_y2;
  logic        o_ln_start;
  logic        i_ln_set_pixel;
  logic [15:0] i_ln_x;
  logic [15:0] i_ln_y;
  logic        i_ln_ready;
  logic        o_pix_we;
  logic [15:0] o_pix_x;
  logic [15:0] o_pix_y;
  logic        o_pix_owner;
  logic        o_busy;
  logic        o_err;
  logic [15:0] o_clip_cnt;

  modport slave (
    input  i_req0_valid, i_req0_line, i_req1_valid, i_req1_line,
    input  i_ln_set_pixel, i_ln_x, i_ln_y, i_ln_ready,
    output o_req0_ack, o_req0_done, o_req1_ack, o_req1_done,
    output o_ln_x1, o_ln_y1, o_ln_x2, o_ln_y2, o_ln_start,
    output o_pix_we, o_pix_x, o_pix_y, o_pix_owner,
    output o_busy, o_err, o_clip_cnt
  );

  modport master (
    output i_req0_valid, i_req0_line, i_req1_valid, i_req1_line,
    output i_ln_set_pixel, i_ln_x, i_ln_y, i_ln_ready,
    input  o_req0_ack, o_req0_done, o_req1_ack, o_req1_done,
    input  o_ln_x1, o_ln_y1, o_ln_x2, o_ln_y2, o_ln_start,
    input  o_pix_we, o_pix_x, o_pix_y, o_pix_owner,
    input  o_busy, o_err, o_clip_cnt
  );
endinterface

// File: rtl/line_cmd_sched.sv
// Round-robin scheduler for two line-draw requesters sharing one Bresenham
// engine; holds the granted endpoints for the whole draw and clips the pixel stream.
module line_cmd_sched #(
  parameter int SCR_W    = 640,
  parameter int SCR_H    = 480,
  parameter int START_TO = 15
) (
  input logic             clk,
  input logic             rst_n,
  line_cmd_sched_if.slave bus
);

  localparam int TO_W = $clog2(START_TO + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(START_TO - 1);
  localparam logic signed [15:0] SCR_W_S = 16'(SCR_W);
  localparam logic signed [15:0] SCR_H_S = 16'(SCR_H);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAW,
    ST_DONE
  } state_t;

  state_t state_q, state_d;
  logic owner_q, owner_d;
  logic rr_q, rr_d;
  logic ack0_q, ack0_d;
  logic ack1_q, ack1_d;
  logic err_q, err_d;
  logic [63:0] line_q, line_d;
  logic [TO_W-1:0] toCnt_q, toCnt_d;
  logic pixWe_q, pixWe_d;
  logic [15:0] pixX_q, pixX_d;
  logic [15:0] pixY_q, pixY_d;
  logic [15:0] clipCnt_q, clipCnt_d;

  logic fwdPix;
  logic inWin;
  logic grant0;
  logic grant1;
  logic signed [15:0] engX;
  logic signed [15:0] engY;

  assign engX = bus.i_ln_x;
  assign engY = bus.i_ln_y;
  // Signed compares so negative engine coordinates count as off-screen.
  assign inWin = (engX >= 16'sd0) && (engX < SCR_W_S) &&
                 (engY >= 16'sd0) && (engY < SCR_H_S);

  assign grant0 = bus.i_req0_valid && (!bus.i_req1_valid || !rr_q);
  assign grant1 = bus.i_req1_valid && !grant0;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    err_d   = err_q;
    line_d  = line_q;
    toCnt_d = toCnt_q;
    fwdPix  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant0 || grant1) begin
          owner_d = grant1;
          line_d  = grant1 ? bus.i_req1_line : bus.i_req0_line;
          ack0_d  = grant0;
          ack1_d  = grant1;
          toCnt_d = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // The engine's first pixel strobe doubles as its start acknowledge.
        if (bus.i_ln_set_pixel) begin
          fwdPix  = 1'b1;
          state_d = ST_DRAW;
        end else if (toCnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          toCnt_d = toCnt_q + 1'b1;
        end
      end
      ST_DRAW: begin
        if (bus.i_ln_set_pixel) begin
          fwdPix = 1'b1;
        end else if (bus.i_ln_ready) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        rr_d    = ~owner_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pixWe_d   = fwdPix && inWin;
    pixX_d    = fwdPix ? bus.i_ln_x : pixX_q;
    pixY_d    = fwdPix ? bus.i_ln_y : pixY_q;
    clipCnt_d = clipCnt_q;
    if (fwdPix && !inWin && (clipCnt_q != 16'hFFFF)) begin
      clipCnt_d = clipCnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      owner_q   <= 1'b0;
      rr_q      <= 1'b0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      err_q     <= 1'b0;
      line_q    <= '0;
      toCnt_q   <= '0;
      pixWe_q   <= 1'b0;
      pixX_q    <= '0;
      pixY_q    <= '0;
      clipCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_q      <= rr_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      err_q     <= err_d;
      line_q    <= line_d;
      toCnt_q   <= toCnt_d;
      pixWe_q   <= pixWe_d;
      pixX_q    <= pixX_d;
      pixY_q    <= pixY_d;
      clipCnt_q <= clipCnt_d;
    end
  end

  assign bus.o_req0_ack  = ack0_q;
  assign bus.o_req1_ack  = ack1_q;
  assign bus.o_req0_done = (state_q == ST_DONE) && !owner_q;
  assign bus.o_req1_done = (state_q == ST_DONE) && owner_q;
  assign bus.o_ln_x1     = line_q[63:48];
  assign bus.o_ln_y1     = line_q[47:32];
  assign bus.o_ln_x2     = line_q[31:16];
  assign bus.o_ln_y2     = line_q[15:0];
  assign bus.o_ln_start  = (state_q == ST_ISSUE);
  assign bus.o_pix_we    = pixWe_q;
  assign bus.o_pix_x     = pixX_q;
  assign bus.o_pix_y     = pixY_q;
  assign bus.o_pix_owner = owner_q;
  assign bus.o_busy      = (state_q != ST_IDLE);
  assign bus.o_err       = err_q;
  assign bus.o_clip_cnt  = clipCnt_q;

endmodule
